// File: rtl/pulse_measure_pkg.sv
// Shared types and constants for the multi-channel pulse period/width meter.
package pulse_measure_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } ch_state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/pulse_measure_ch.sv
// One pulse channel: input synchroniser, edge detect, timestamp FSM and result registers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no rise timestamp held; waits for the first rise
// ST_ARMED | one rise captured, period not yet known; width measurable
// ST_RUN   | at least two rises seen; period and width both tracked
module pulse_measure_ch
    import pulse_measure_pkg::*;
#(
    parameter int CW  = 32,
    parameter int TMO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          pulse,
    input  logic [CW-1:0] count,
    output logic [CW-1:0] period,
    output logic [CW-1:0] width,
    output logic          per_vld,
    output logic          wid_vld,
    output logic          stale
);

    localparam logic [CW-1:0] TMO_CW = CW'(TMO);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  dly_q;
    logic                  sig;
    logic                  rise;
    logic                  fall;
    logic                  timeout;
    logic [CW-1:0]         t_rise;
    logic [CW-1:0]         elapsed;
    ch_state_t             state;

    assign sig  = sync_q[SYNC_DEPTH-1];
    assign rise = sig & ~dly_q;
    assign fall = ~sig & dly_q;

    // Modulo-2^CW difference: a single counter wrap between edges stays exact.
    assign elapsed = count - t_rise;
    assign timeout = (TMO != 0) && (elapsed >= TMO_CW);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            dly_q   <= 1'b0;
            state   <= ST_IDLE;
            t_rise  <= '0;
            period  <= '0;
            width   <= '0;
            per_vld <= 1'b0;
            wid_vld <= 1'b0;
            stale   <= 1'b0;
        end else begin
            // Synchroniser keeps running while disabled so re-enable sees no false edge.
            sync_q  <= {sync_q[SYNC_DEPTH-2:0], pulse};
            dly_q   <= sig;
            per_vld <= 1'b0;
            wid_vld <= 1'b0;
            if (!ena) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            t_rise <= count;
                            state  <= ST_ARMED;
                        end
                    end
                    ST_ARMED, ST_RUN: begin
                        if (fall) begin
                            width   <= elapsed;
                            wid_vld <= 1'b1;
                        end
                        if (rise) begin
                            period  <= elapsed;
                            per_vld <= 1'b1;
                            stale   <= 1'b0;
                            t_rise  <= count;
                            state   <= ST_RUN;
                        end else if (timeout) begin
                            stale <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/pulse_measure_mc.sv
// NCH independent pulse channels sharing one timestamp counter; results packed CW bits per lane.
module pulse_measure_mc
    import pulse_measure_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int TMO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NCH-1:0]    pulse,
    input  logic [CW-1:0]     count,
    output logic [NCH*CW-1:0] period,
    output logic [NCH*CW-1:0] width,
    output logic [NCH-1:0]    per_vld,
    output logic [NCH-1:0]    wid_vld,
    output logic [NCH-1:0]    stale
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pulse_measure_ch #(
            .CW  (CW),
            .TMO (TMO)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ena     (ena),
            .pulse   (pulse[i]),
            .count   (count),
            .period  (period[i*CW +: CW]),
            .width   (width[i*CW +: CW]),
            .per_vld (per_vld[i]),
            .wid_vld (wid_vld[i]),
            .stale   (stale[i])
        );
    end

endmodule

// File: doc/pulse_measure_mc.md
# pulse_measure_mc

Multi-channel, parametrised pulse period/width meter. It timestamps the edges of `NCH` independent pulse inputs against a shared free-running counter and reports per-channel period (rise-to-rise) and high width (rise-to-fall). Each result comes with a one-cycle valid strobe and a stale/timeout flag. It sits between the acquisition front end (pulse inputs, global timestamp counter) and the register/readout logic of sig_acq.

## Interface
- `NCH`, default 4: number of pulse channels.
- `CW`, default 32: timestamp and result width in bits.
- `TMO`, default 0: timeout in clock ticks; 0 disables the timeout.
- `clk`  in  1: single clock domain for the whole block.
- `rst`  in  1: reset, synchronous, active-high.
- `ena`  in  1: global enable. Low forces every channel to IDLE.
- `pulse`  in  NCH: asynchronous pulse inputs, one bit per channel.
- `count`  in  CW: free-running timestamp, increments by 1 per `clk` and wraps modulo 2^CW.
- `period`  out  NCH*CW: channel i occupies `[i*CW +: CW]`. Last period.
- `width`  out  NCH*CW: same packing. Last high width.
- `per_vld`  out  NCH: one-cycle strobe when `period` lane i updates.
- `wid_vld`  out  NCH: one-cycle strobe when `width` lane i updates.
- `stale`  out  NCH: sticky flag; no rising edge seen within `TMO` ticks.

## Operation
- Per channel: 2-FF synchroniser, then a delay flop for edge detection. `rise` = sync high and delay low; `fall` = sync low and delay high.
- Per-channel FSM has three states:
  - IDLE: no timestamp held. On `rise`: `t_rise <= count`, go to ARMED.
  - ARMED: one rise captured, period not yet valid.
    - On `fall`: `width <= count - t_rise`, pulse `wid_vld`.
    - On `rise`: `period <= count - t_rise`, pulse `per_vld`, `t_rise <= count`, go to RUN.
  - RUN: same actions as ARMED on `fall` and `rise`; stay in RUN.
- All subtraction is modulo 2^CW (plain CW-bit unsigned difference), so one counter wrap between edges is exact. Intervals of 2^CW ticks or more alias and are out of scope.
- A `fall` in IDLE is ignored: no width is reported without a preceding rise.
- Timeout (`TMO` ≠ 0): in ARMED or RUN, when `count - t_rise >= TMO` and no `rise` occurs that cycle, set `stale[i]` and go to IDLE. `period` and `width` hold their values.
- `stale[i]` clears on the next `per_vld[i]`.
- `ena` low: every FSM goes to IDLE, no strobes are issued, and outputs hold. Synchroniser flops keep running, so no false edge appears when `ena` returns.

## Timing
- Reset values: `period`, `width`, `per_vld`, `wid_vld`, `stale` are all 0. FSM is in IDLE. `t_rise` is 0. Synchroniser and delay flops are 0.
- Latency: a `pulse` transition produces a `rise`/`fall` 3 cycles later, in cycle E. `count` is sampled in cycle E. Every edge has the same latency, so differences are exact in clock ticks.
- Result registers and strobes update on the clock edge ending cycle E, so they are visible in cycle E+1. Strobes are high for exactly one cycle.
- A `rise` and a timeout in the same cycle: the rise wins and no stale flag is set.
- A `fall` and a `rise` in the same cycle are impossible per channel, because the input is a single synchronised bit.
- Channels are fully independent. Simultaneous strobes on several channels are legal.
- `rst` asserted mid-measurement: everything returns to reset values on the next clock edge, and any partial interval is discarded.
- Pulses shorter than 1 `clk` period may be missed. The minimum reliable high or low time is 2 `clk` periods.

## Structure
- Package `pulse_measure_pkg`:
  - FSM state encoding: `ST_IDLE`, `ST_ARMED`, `ST_RUN`, 2 bits.
  - Synchroniser depth constant `SYNC_DEPTH = 2`.
- Sub-module `pulse_measure_ch`:
  - Handles one channel: synchroniser, edge detect, FSM, `t_rise`, and the period, width and stale registers.
  - Parameters: `CW`, `TMO`.
- `pulse_measure_mc` is a generate loop of `NCH` instances of `pulse_measure_ch` plus output lane packing. It has no other logic.

## Test plan
- Basic: ch0 square wave, period 100 clk, high 30 clk. The first `wid_vld` gives `width` = 30; `per_vld` stays silent until the second rise, which gives `period` = 100; `stale` stays 0.
- Wrap: `CW`=8, `count` starting at 250, edges at count 250 then 250+20, so `count` wraps to 14 at the second rise. Required: `period` = 20, no sign or extension artefacts.
- Timeout: `TMO`=50, one rise, then none. Required: `stale[0]` = 1 at 50 ticks after `t_rise` plus 1 cycle, and FSM in IDLE. A later pair of rises 40 apart gives `period` = 40 with `stale` cleared in the same cycle as `per_vld`.
- Multi-channel: `NCH`=4 with periods 37/64/100/255, all started in the same cycle. Each lane reports its own value, strobes coincide where edges coincide, and there is no cross-talk.
- `ena`/reset: `ena` dropped for 200 cycles mid-run gives no strobes and held outputs; after `ena` returns, the first `per_vld` appears only after two new rises. A `rst` pulse mid-pulse zeroes all outputs on the next cycle, and the next measurement is correct.
